// File: rtl/wb_bus_mux.sv
// ---------------------------------------------------------------------------
// wb_bus_mux
//
// Single-master pipelined Wishbone multiplexer fanning one master out to NS
// slaves. The master request is latched and decoded against a per-slave
// base/mask table, with the lowest matching index winning. The block makes
// sure the master always receives a termination:
//   - an address that matches no slave is answered with wbm_err_o.
//   - a slave that never answers is cut off by a watchdog, and the master
//     sees wbm_err_o.
// The most recent bus fault is recorded in the err_* status outputs.
//
// Ports
//   wb_clk_i / wb_rst_i          clock, asynchronous active-low reset
//   wbm_cyc/stb/we/adr/dat/sel_i master request
//   wbm_dat_o/ack_o/err_o        registered master response
//   wbm_stall_o                  high while a transaction is outstanding
//   wbs_cyc_o/stb_o [NS]         per-slave cycle and strobe
//   wbs_we/adr/dat/sel_o         shared, latched request fields
//   wbs_dat_i [NS*DW]            packed slave read data
//   wbs_ack/err/stall_i [NS]     per-slave responses
//   err_clr_i                    clears err_valid_o
//   err_valid/cause/adr/count_o  last-fault record
//                                cause: 01 miss, 10 timeout, 11 slave err
// ---------------------------------------------------------------------------
module wb_bus_mux #(
  parameter int                NS             = 6,
  parameter int                AW             = 32,
  parameter int                DW             = 32,
  parameter logic [NS*AW-1:0]  SLAVE_ADDR     = '0,
  parameter logic [NS*AW-1:0]  SLAVE_MASK     = '0,
  parameter int                TIMEOUT_CYCLES = 256
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbm_cyc_i,
  input  logic               wbm_stb_i,
  input  logic               wbm_we_i,
  input  logic [AW-1:0]      wbm_adr_i,
  input  logic [DW-1:0]      wbm_dat_i,
  input  logic [DW/8-1:0]    wbm_sel_i,
  output logic [DW-1:0]      wbm_dat_o,
  output logic               wbm_ack_o,
  output logic               wbm_err_o,
  output logic               wbm_stall_o,
  output logic [NS-1:0]      wbs_cyc_o,
  output logic [NS-1:0]      wbs_stb_o,
  output logic               wbs_we_o,
  output logic [AW-1:0]      wbs_adr_o,
  output logic [DW-1:0]      wbs_dat_o,
  output logic [DW/8-1:0]    wbs_sel_o,
  input  logic [NS*DW-1:0]   wbs_dat_i,
  input  logic [NS-1:0]      wbs_ack_i,
  input  logic [NS-1:0]      wbs_err_i,
  input  logic [NS-1:0]      wbs_stall_i,
  input  logic               err_clr_i,
  output logic               err_valid_o,
  output logic [1:0]         err_cause_o,
  output logic [AW-1:0]      err_adr_o,
  output logic [7:0]         err_count_o
);

  localparam int SW   = DW / 8;
  localparam int IW   = (NS > 1) ? $clog2(NS) : 1;
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT =
    WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [1:0] CAUSE_MISS    = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [1:0] CAUSE_SLV_ERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [IW-1:0]     r_idx;
  logic [WD_W-1:0]   r_wd_cnt;
  logic              r_we;
  logic [AW-1:0]     r_adr;
  logic [DW-1:0]     r_dat;
  logic [SW-1:0]     r_sel;
  logic              r_ack;
  logic              r_err;
  logic [DW-1:0]     r_rdat;
  logic              r_err_valid;
  logic [1:0]        r_err_cause;
  logic [AW-1:0]     r_err_adr;
  logic [7:0]        r_err_count;

  logic              w_hit;
  logic [IW-1:0]     w_hit_idx;
  logic              w_accept;
  logic              w_miss;
  logic              w_done_ack;
  logic              w_done_err;
  logic              w_timeout;
  logic              w_fault;
  logic [1:0]        w_fault_cause;
  logic [AW-1:0]     w_fault_adr;
  logic              w_sel_ack;
  logic              w_sel_err;
  logic              w_sel_stall;
  logic [DW-1:0]     w_sel_dat;
  logic              w_resp_ok;
  logic              w_wd_expired;

  // Address decode. Scanning from the top index down lets the lowest
  // matching slave overwrite any higher one, so it wins.
  // NOTE: every variable written in an always_comb gets a default first;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if ((wbm_adr_i & SLAVE_MASK[AW*i +: AW]) ==
          (SLAVE_ADDR[AW*i +: AW] & SLAVE_MASK[AW*i +: AW])) begin
        w_hit     = 1'b1;
        w_hit_idx = IW'(i);
      end
    end
  end

  // Responses of the currently selected slave.
  assign w_sel_ack    = wbs_ack_i[r_idx];
  assign w_sel_err    = wbs_err_i[r_idx];
  assign w_sel_stall  = wbs_stall_i[r_idx];
  assign w_sel_dat    = wbs_dat_i[r_idx*DW +: DW];

  // A slave response counts once the strobe has been taken (REQ without
  // stall) or while waiting in RESP.
  assign w_resp_ok    = (r_state == ST_RESP) || !w_sel_stall;
  assign w_wd_expired = (TIMEOUT_CYCLES != 0) && (r_wd_cnt == WD_LIMIT);

  // Next-state and termination decode. Master abort has top priority,
  // then slave err over ack, then ack over the watchdog.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_miss      = 1'b0;
    w_done_ack  = 1'b0;
    w_done_err  = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          if (w_hit) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_REQ;
          end else begin
            w_miss      = 1'b1;
          end
        end
      end
      ST_REQ, ST_RESP: begin
        if (!wbm_cyc_i) begin
          w_state_nxt = ST_IDLE;
        end else if (w_resp_ok && w_sel_err) begin
          w_done_err  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_resp_ok && w_sel_ack) begin
          w_done_ack  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_wd_expired) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_state == ST_REQ && !w_sel_stall) begin
          w_state_nxt = ST_RESP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_fault = w_miss || w_done_err || w_timeout;

  always_comb begin
    w_fault_cause = CAUSE_SLV_ERR;
    w_fault_adr   = r_adr;
    if (w_miss) begin
      w_fault_cause = CAUSE_MISS;
      w_fault_adr   = wbm_adr_i;   // not latched yet in the miss cycle
    end else if (w_timeout) begin
      w_fault_cause = CAUSE_TIMEOUT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_wd_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_idx    <= w_hit_idx;
        r_wd_cnt <= '0;
      end else if (r_state != ST_IDLE) begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end
    end
  end

  // Request latch and registered master response.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_we   <= 1'b0;
      r_adr  <= '0;
      r_dat  <= '0;
      r_sel  <= '0;
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_rdat <= '0;
    end else begin
      if (r_state == ST_IDLE && wbm_cyc_i && wbm_stb_i) begin
        r_we  <= wbm_we_i;
        r_adr <= wbm_adr_i;
        r_dat <= wbm_dat_i;
        r_sel <= wbm_sel_i;
      end
      r_ack <= w_done_ack;
      r_err <= w_fault;
      if (w_done_ack) begin
        r_rdat <= w_sel_dat;
      end
    end
  end

  // Fault record. A fault in the same cycle as err_clr_i keeps valid set.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_err_valid <= 1'b0;
      r_err_cause <= 2'b00;
      r_err_adr   <= '0;
      r_err_count <= 8'd0;
    end else begin
      if (w_fault) begin
        r_err_valid <= 1'b1;
        r_err_cause <= w_fault_cause;
        r_err_adr   <= w_fault_adr;
        if (r_err_count != 8'hFF) begin
          r_err_count <= r_err_count + 8'd1;
        end
      end else if (err_clr_i) begin
        r_err_valid <= 1'b0;
      end
    end
  end

  // Slave-side strobes come straight from the state register, so a reset or
  // exit from REQ/RESP drops them without waiting for an edge.
  assign wbs_cyc_o   = (r_state != ST_IDLE) ? (NS'(1) << r_idx) : '0;
  assign wbs_stb_o   = (r_state == ST_REQ)  ? (NS'(1) << r_idx) : '0;
  assign wbm_stall_o = (r_state != ST_IDLE);

  assign wbs_we_o    = r_we;
  assign wbs_adr_o   = r_adr;
  assign wbs_dat_o   = r_dat;
  assign wbs_sel_o   = r_sel;

  assign wbm_dat_o   = r_rdat;
  assign wbm_ack_o   = r_ack;
  assign wbm_err_o   = r_err;

  assign err_valid_o = r_err_valid;
  assign err_cause_o = r_err_cause;
  assign err_adr_o   = r_err_adr;
  assign err_count_o = r_err_count;

endmodule

// File: tb/tb_wb_bus_mux.sv
// ---------------------------------------------------------------------------
// tb_wb_bus_mux
//
// Directed bench for wb_bus_mux (NS=6, TIMEOUT_CYCLES=16). The slave side is
// driven cycle by cycle from the stimulus sequence; expected values are
// written out by hand. Cycle numbers in comments count from the cycle in
// which the master request is presented (cycle 0).
//
// Address map used here:
//   slave 0..4 : 0x0N00_0000 / mask 0xFF00_0000
//   slave 5    : 0x0400_0000 / mask 0xFE00_0000 (overlaps slave 4)
// ---------------------------------------------------------------------------
module tb_wb_bus_mux;

  localparam int NS = 6;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  localparam logic [NS*AW-1:0] MAP_ADDR = {
    32'h0400_0000, 32'h0400_0000, 32'h0300_0000,
    32'h0200_0000, 32'h0100_0000, 32'h0000_0000 };
  localparam logic [NS*AW-1:0] MAP_MASK = {
    32'hFE00_0000, 32'hFF00_0000, 32'hFF00_0000,
    32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000 };

  logic               clk = 1'b0;
  logic               rst_n;
  logic               wbm_cyc_i, wbm_stb_i, wbm_we_i;
  logic [AW-1:0]      wbm_adr_i;
  logic [DW-1:0]      wbm_dat_i;
  logic [DW/8-1:0]    wbm_sel_i;
  logic [DW-1:0]      wbm_dat_o;
  logic               wbm_ack_o, wbm_err_o, wbm_stall_o;
  logic [NS-1:0]      wbs_cyc_o, wbs_stb_o;
  logic               wbs_we_o;
  logic [AW-1:0]      wbs_adr_o;
  logic [DW-1:0]      wbs_dat_o;
  logic [DW/8-1:0]    wbs_sel_o;
  logic [NS*DW-1:0]   wbs_dat_i;
  logic [NS-1:0]      wbs_ack_i, wbs_err_i, wbs_stall_i;
  logic               err_clr_i;
  logic               err_valid_o;
  logic [1:0]         err_cause_o;
  logic [AW-1:0]      err_adr_o;
  logic [7:0]         err_count_o;

  int n_vec  = 0;
  int n_miss = 0;

  wb_bus_mux #(
    .NS(NS), .AW(AW), .DW(DW),
    .SLAVE_ADDR(MAP_ADDR), .SLAVE_MASK(MAP_MASK),
    .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst_n),
    .wbm_cyc_i  (wbm_cyc_i),
    .wbm_stb_i  (wbm_stb_i),
    .wbm_we_i   (wbm_we_i),
    .wbm_adr_i  (wbm_adr_i),
    .wbm_dat_i  (wbm_dat_i),
    .wbm_sel_i  (wbm_sel_i),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_ack_o  (wbm_ack_o),
    .wbm_err_o  (wbm_err_o),
    .wbm_stall_o(wbm_stall_o),
    .wbs_cyc_o  (wbs_cyc_o),
    .wbs_stb_o  (wbs_stb_o),
    .wbs_we_o   (wbs_we_o),
    .wbs_adr_o  (wbs_adr_o),
    .wbs_dat_o  (wbs_dat_o),
    .wbs_sel_o  (wbs_sel_o),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_ack_i  (wbs_ack_i),
    .wbs_err_i  (wbs_err_i),
    .wbs_stall_i(wbs_stall_i),
    .err_clr_i  (err_clr_i),
    .err_valid_o(err_valid_o),
    .err_cause_o(err_cause_o),
    .err_adr_o  (err_adr_o),
    .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] adr, input logic we,
                     input logic [31:0] dat);
    wbm_cyc_i = 1'b1;
    wbm_stb_i = 1'b1;
    wbm_we_i  = we;
    wbm_adr_i = adr;
    wbm_dat_i = dat;
    wbm_sel_i = 4'hF;
  endtask

  initial begin
    rst_n       = 1'b0;
    wbm_cyc_i   = 1'b0;
    wbm_stb_i   = 1'b0;
    wbm_we_i    = 1'b0;
    wbm_adr_i   = '0;
    wbm_dat_i   = '0;
    wbm_sel_i   = '0;
    wbs_ack_i   = '0;
    wbs_err_i   = '0;
    wbs_stall_i = '0;
    err_clr_i   = 1'b0;
    for (int i = 0; i < NS; i++) begin
      wbs_dat_i[i*DW +: DW] = 32'hD000_0000 + 32'(i) * 32'h11;
    end

    // ---- reset state ----
    #12;
    check("rst_cyc",   wbs_cyc_o,   6'b0);
    check("rst_ack",   wbm_ack_o,   1'b0);
    check("rst_dat",   wbm_dat_o,   32'h0);
    check("rst_count", err_count_o, 8'd0);
    check("rst_valid", err_valid_o, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // ---- read to GPIO (slave 2), ack one cycle after stb ----
    req(32'h0200_0004, 1'b0, 32'h0);                  // cycle 0
    check("rd_idle_stall", wbm_stall_o, 1'b0);
    check("rd_idle_cyc",   wbs_cyc_o,   6'b0);
    tick(); wbm_stb_i = 1'b0;                         // cycle 1
    check("rd_stb",   wbs_stb_o,   6'b000100);
    check("rd_cyc",   wbs_cyc_o,   6'b000100);
    check("rd_stall", wbm_stall_o, 1'b1);
    check("rd_adr",   wbs_adr_o,   32'h0200_0004);
    tick();                                           // cycle 2
    check("rd_resp_stb", wbs_stb_o, 6'b0);
    check("rd_resp_cyc", wbs_cyc_o, 6'b000100);
    wbs_ack_i = 6'b000100;
    tick();                                           // cycle 3
    wbs_ack_i = '0;
    check("rd_ack",     wbm_ack_o, 1'b1);
    check("rd_dat",     wbm_dat_o, 32'hD000_0022);
    check("rd_cyc_end", wbs_cyc_o, 6'b0);
    wbm_cyc_i = 1'b0;
    tick();                                           // cycle 4
    check("rd_ack_pulse", wbm_ack_o, 1'b0);

    // ---- decode miss ----
    req(32'h0A00_0000, 1'b0, 32'h0);                  // cycle 0
    tick(); wbm_stb_i = 1'b0; wbm_cyc_i = 1'b0;       // cycle 1
    check("miss_err",   wbm_err_o,   1'b1);
    check("miss_cyc",   wbs_cyc_o,   6'b0);
    check("miss_cause", err_cause_o, 2'b01);
    check("miss_adr",   err_adr_o,   32'h0A00_0000);
    check("miss_count", err_count_o, 8'd1);
    check("miss_valid", err_valid_o, 1'b1);
    check("miss_dat_hold", wbm_dat_o, 32'hD000_0022);

    // ---- timeout on slave 3 (write) ----
    req(32'h0300_0000, 1'b1, 32'h1234_5678);          // cycle 0
    tick(); wbm_stb_i = 1'b0;                         // cycle 1
    check("to_stb", wbs_stb_o, 6'b001000);
    check("to_we",  wbs_we_o,  1'b1);
    check("to_wdat", wbs_dat_o, 32'h1234_5678);
    repeat (TO - 1) tick();                           // cycle 16
    check("to_cyc_c16", wbs_cyc_o, 6'b001000);
    check("to_err_c16", wbm_err_o, 1'b0);
    tick();                                           // cycle 17
    check("to_cyc_c17", wbs_cyc_o,   6'b0);
    check("to_err_c17", wbm_err_o,   1'b1);
    check("to_cause",   err_cause_o, 2'b10);
    check("to_adr",     err_adr_o,   32'h0300_0000);
    check("to_count",   err_count_o, 8'd2);
    wbm_cyc_i = 1'b0;
    tick();
    check("to_err_pulse", wbm_err_o, 1'b0);

    // ---- ack at the last watchdog cycle beats timeout (slave 1) ----
    req(32'h0100_0010, 1'b0, 32'h0);                  // cycle 0
    tick(); wbm_stb_i = 1'b0;                         // cycle 1
    repeat (TO - 1) tick();                           // cycle 16
    wbs_ack_i = 6'b000010;
    tick();                                           // cycle 17
    wbs_ack_i = '0;
    check("late_ack",   wbm_ack_o,   1'b1);
    check("late_noerr", wbm_err_o,   1'b0);
    check("late_dat",   wbm_dat_o,   32'hD000_0011);
    check("late_count", err_count_o, 8'd2);
    wbm_cyc_i = 1'b0;
    tick();

    // ---- 5 stall cycles then ack with stb; overlap decode picks slave 4 ----
    wbs_stall_i = 6'b010000;
    req(32'h0400_0000, 1'b0, 32'h0);                  // cycle 0
    tick(); wbm_stb_i = 1'b0;                         // cycle 1
    check("stall_stb_c1", wbs_stb_o, 6'b010000);
    repeat (5) tick();                                // cycle 6
    check("stall_stb_c6", wbs_stb_o, 6'b010000);
    wbs_stall_i = '0;
    wbs_ack_i   = 6'b010000;
    tick();                                           // cycle 7
    wbs_ack_i = '0;
    check("stall_ack",    wbm_ack_o, 1'b1);
    check("stall_no_stb", wbs_stb_o, 6'b0);
    check("stall_dat",    wbm_dat_o, 32'hD000_0044);
    wbm_cyc_i = 1'b0;
    tick();

    // ---- master abort in RESP, late ack ignored (slave 5) ----
    req(32'h0500_0000, 1'b0, 32'h0);                  // cycle 0
    tick(); wbm_stb_i = 1'b0;                         // cycle 1
    check("abort_stb", wbs_stb_o, 6'b100000);
    tick();                                           // cycle 2
    check("abort_resp_cyc", wbs_cyc_o, 6'b100000);
    wbm_cyc_i = 1'b0;
    tick();                                           // cycle 3
    check("abort_cyc",   wbs_cyc_o,   6'b0);
    check("abort_stall", wbm_stall_o, 1'b0);
    check("abort_noack", wbm_ack_o,   1'b0);
    wbs_ack_i = 6'b100000;
    tick();                                           // cycle 4
    wbs_ack_i = '0;
    check("abort_late_ack", wbm_ack_o, 1'b0);
    check("abort_late_err", wbm_err_o, 1'b0);
    wbs_dat_i[2*DW +: DW] = 32'hBEEF_0002;
    req(32'h0200_0008, 1'b0, 32'h0);                  // cycle 0
    tick(); wbm_stb_i = 1'b0;                         // cycle 1
    check("post_abort_stb", wbs_stb_o, 6'b000100);
    tick();                                           // cycle 2
    wbs_ack_i = 6'b000100;
    tick();                                           // cycle 3
    wbs_ack_i = '0;
    check("post_abort_ack", wbm_ack_o, 1'b1);
    check("post_abort_dat", wbm_dat_o, 32'hBEEF_0002);
    wbm_cyc_i = 1'b0;
    tick();

    // ---- slave err + ack + err_clr in one cycle (slave 0) ----
    req(32'h0000_0100, 1'b0, 32'h0);                  // cycle 0
    tick(); wbm_stb_i = 1'b0;                         // cycle 1
    tick();                                           // cycle 2
    wbs_ack_i = 6'b000001;
    wbs_err_i = 6'b000001;
    err_clr_i = 1'b1;
    tick();                                           // cycle 3
    wbs_ack_i = '0;
    wbs_err_i = '0;
    err_clr_i = 1'b0;
    check("serr_err",   wbm_err_o,   1'b1);
    check("serr_noack", wbm_ack_o,   1'b0);
    check("serr_valid", err_valid_o, 1'b1);
    check("serr_cause", err_cause_o, 2'b11);
    check("serr_adr",   err_adr_o,   32'h0000_0100);
    check("serr_count", err_count_o, 8'd3);
    check("serr_dat_hold", wbm_dat_o, 32'hBEEF_0002);
    wbm_cyc_i = 1'b0;
    tick();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("clr_valid", err_valid_o, 1'b0);
    check("clr_count", err_count_o, 8'd3);
    check("clr_cause", err_cause_o, 2'b11);

    // ---- 300 back-to-back decode misses saturate the counter ----
    req(32'h0A00_0000, 1'b0, 32'h0);
    repeat (100) tick();
    check("sat_count_103", err_count_o, 8'd103);
    repeat (200) tick();
    wbm_cyc_i = 1'b0;
    wbm_stb_i = 1'b0;
    check("sat_count_255", err_count_o, 8'd255);
    check("sat_cause",     err_cause_o, 2'b01);
    check("sat_valid",     err_valid_o, 1'b1);
    tick();
    check("sat_hold",      err_count_o, 8'd255);
    check("sat_err_done",  wbm_err_o,   1'b0);

    // ---- asynchronous reset mid-transaction ----
    req(32'h0200_0000, 1'b0, 32'h0);                  // cycle 0
    tick(); wbm_stb_i = 1'b0;                         // cycle 1
    check("mrst_cyc_before", wbs_cyc_o, 6'b000100);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_cyc",   wbs_cyc_o,   6'b0);
    check("mrst_stall", wbm_stall_o, 1'b0);
    check("mrst_count", err_count_o, 8'd0);
    check("mrst_dat",   wbm_dat_o,   32'h0);
    check("mrst_adr",   err_adr_o,   32'h0);
    wbm_cyc_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
